// File: rtl/div_iter_if.sv
// div_iter_if: operand/result bundle between EX and div_iter; master = EX side, slave = divider
interface div_iter_if #(parameter int WIDTH = 32);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;
  modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, input result_o, ready_o, busy_o);
  modport slave (input signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, output result_o, ready_o, busy_o);
endinterface

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider, {rem,quo} on bus.result_o; ports clk, rst (async high), bus (div_iter_if.slave); DIV_ITER_EARLY_OUT_EN enables early-out
module div_iter #(parameter int WIDTH = 32) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;
  state_t state;
  logic [CW-1:0] cnt, k;
  logic [WIDTH-1:0] dvd, dvs, rem, quo, abs1, abs2, rem_fix, quo_fix;
  logic [WIDTH:0] rem_sh, diff;
  logic [2*WIDTH-1:0] result;
  logic sign_q, sign_r, sign1, sign2, ready, busy;
  always_comb begin
    sign1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    sign2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    abs1 = sign1 ? -bus.opdata1_i : bus.opdata1_i;
    abs2 = sign2 ? -bus.opdata2_i : bus.opdata2_i;
    rem_sh = {rem, dvd[WIDTH-1]};
    diff = rem_sh - {1'b0, dvs};
    rem_fix = sign_r ? -rem : rem;
    quo_fix = sign_q ? -quo : quo;
  end
`ifdef DIV_ITER_EARLY_OUT_EN
  logic [CW-1:0] n;
  always_comb begin
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = abs1[i] ? CW'(i + 1) : n;
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      result <= '0;
      ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start_i && !bus.annul_i) begin
          busy <= 1'b1;
          cnt <= '0;
          rem <= '0;
          quo <= '0;
          if (bus.opdata2_i == '0) begin
            state <= DIVZERO;
            dvd <= bus.opdata1_i;
          end else begin
            state <= ON;
            dvs <= abs2;
            sign_q <= sign1 ^ sign2;
            sign_r <= sign1;
`ifdef DIV_ITER_EARLY_OUT_EN
            // left-align the magnitude so only its significant bits are iterated
            k <= (n == '0) ? CW'(1) : n;
            dvd <= abs1 << (CW'(WIDTH) - n);
`else
            k <= CW'(WIDTH);
            dvd <= abs1;
`endif
          end
        end
        DIVZERO: begin
          busy <= 1'b0;
          if (bus.annul_i) state <= IDLE;
          else begin
            result <= {dvd, {WIDTH{1'b1}}};
            ready <= 1'b1;
            state <= END;
          end
        end
        ON: if (bus.annul_i || !bus.start_i) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (cnt == k) begin
          result <= {rem_fix, quo_fix};
          ready <= 1'b1;
          busy <= 1'b0;
          state <= END;
        end else begin
          // diff[WIDTH] is the borrow: set means the trial subtract went negative
          rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          dvd <= dvd << 1;
          cnt <= cnt + CW'(1);
        end
        END: if (!bus.start_i) begin
          state <= IDLE;
          ready <= 1'b0;
          result <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.result_o = result;
  assign bus.ready_o = ready;
  assign bus.busy_o = busy;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter (WIDTH=32) against an arithmetic reference model
module tb_div_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  typedef struct {
    logic [63:0] res;
    int cyc;
  } exp_t;
  exp_t sb[$];
  logic ready_d = 1'b0;
  div_iter_if #(32) bus();
  div_iter #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic logic [63:0] model(logic s, logic [31:0] a, logic [31:0] b);
    longint sa, sb_, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    sa = s ? longint'($signed(a)) : longint'(a);
    sb_ = s ? longint'($signed(b)) : longint'(b);
    q = sa / sb_;
    r = sa % sb_;
    return {r[31:0], q[31:0]};
  endfunction
  function automatic int latency(logic s, logic [31:0] a, logic [31:0] b);
    logic [31:0] m;
    int n;
    if (b == 0) return 1;
    m = (s && a[31]) ? -a : a;
    n = 0;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
`ifdef DIV_ITER_EARLY_OUT_EN
    return (n == 0 ? 1 : n) + 1;
`else
    return 33;
`endif
  endfunction
  always @(negedge clk) begin
    if (bus.ready_o && !ready_d) begin
      if (sb.size() == 0) check("unexpected_ready", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result_o, e.res);
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    ready_d = bus.ready_o;
  end
  task automatic issue(logic s, logic [31:0] a, logic [31:0] b);
    exp_t e;
    bus.signed_div_i = s;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.start_i = 1'b1;
    bus.annul_i = 1'b0;
    e.res = model(s, a, b);
    e.cyc = cyc + 1 + latency(s, a, b);
    sb.push_back(e);
  endtask
  task automatic complete(int hold);
    bit got;
    got = 0;
    @(negedge clk);
    check("busy_after_capture", 64'(bus.busy_o), 64'd1);
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    bus.signed_div_i = ~bus.signed_div_i;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.ready_o) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      check("ready_timeout", 64'd0, 64'd1);
      sb.delete();
    end
    check("busy_at_ready", 64'(bus.busy_o), 64'd0);
    repeat (hold) @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    check("cleared_after_drop", {63'(bus.result_o[62:0]) | 63'(bus.result_o[63]), bus.ready_o}, 64'd0);
  endtask
  task automatic run_op(logic s, logic [31:0] a, logic [31:0] b, int hold);
    @(negedge clk);
    issue(s, a, b);
    complete(hold);
  endtask
  initial begin
    logic [31:0] a, b;
    logic s;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(negedge clk);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_flags", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    rst = 1'b0;
    run_op(0, 100, 7, 2);
    run_op(1, 32'hFFFF_FFF9, 32'h2, 0);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(1, 5, 0, 0);
    run_op(0, 5, 0, 3);
    run_op(0, 0, 9, 0);
    run_op(0, 32'hFFFF_FFFF, 1, 0);
    run_op(1, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    @(negedge clk);
    issue(0, 100, 7);
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    check("annul_flags", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    issue(0, 9, 3);
    complete(0);
    @(negedge clk);
    issue(1, 32'hFFFF_0000, 3);
    repeat (4) @(negedge clk);
    bus.start_i = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("drop_flags", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    @(negedge clk);
    issue(0, 1000, 3);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_result", bus.result_o, 64'd0);
    check("async_reset_flags", {62'd0, bus.ready_o, bus.busy_o}, 64'd0);
    sb.delete();
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 1, 1, 0);
    for (int t = 0; t < 40; t++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_op(s, a, b, $urandom_range(0, 2));
    end
    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
